ilas_seq: RTL

- Generates the JESD204B Initial Lane Alignment Sequence (ILAS) octet stream for one lane.
- Sits directly upstream of the config ROM: drives its read address and read enable, and consumes its registered 1-cycle-latency output.
- The link configuration octets are inserted into multiframe 1.
- Output feeds the 8b/10b encoder stage: one octet per clock, with a K-character flag.

---
 rtl/jesd_pkg.sv | 10 +
 rtl/ilas_seq_if.sv | 20 ++
 rtl/ilas_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jesd_pkg.sv
// Shared JESD204B link constants and the ILAS sequencer state type.
package jesd_pkg;
  localparam logic [7:0] K_R = 8'h1C;
  localparam logic [7:0] K_Q = 8'h9C;
  localparam logic [7:0] K_A = 8'h7C;
  localparam int CFG_LEN       = 14;
  localparam int CFG_POS_FIRST = 2;

  typedef enum logic {IDLE, RUN} ilas_state_t;
endpackage

// File: rtl/ilas_seq_if.sv
// Config-ROM fetch and ILAS octet stream bundle for one lane.
interface ilas_seq_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic                  o_rom_rd_en;
  logic [7:0]            i_rom_data;
  logic                  o_valid;
  logic [7:0]            o_data;
  logic                  o_is_k;

  modport master (
    output o_rom_addr, o_rom_rd_en, o_valid, o_data, o_is_k,
    input  i_rom_data
  );
  modport slave (
    input  o_rom_addr, o_rom_rd_en, o_valid, o_data, o_is_k,
    output i_rom_data
  );
endinterface

// File: rtl/ilas_seq.sv
// JESD204B ILAS octet generator for one lane; config octets fetched from ROM into multiframe 1.
// Optional macro ILAS_CHKSUM_EN replaces config octet 13 with a mod-256 sum of octets 0..12.
module ilas_seq
  import jesd_pkg::*;
#(
  parameter int MF_LEN     = 32,
  parameter int NUM_MF     = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int CFG_BASE   = 0,
  parameter int CFG_LEN    = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  ilas_seq_if.master bus,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [7:0] POS_LAST     = 8'(MF_LEN - 1);
  localparam logic [3:0] MF_LAST      = 4'(NUM_MF - 1);
  localparam logic [7:0] CFG_RD_FIRST = 8'(CFG_POS_FIRST - 1);
  localparam logic [7:0] CFG_RD_LAST  = 8'(CFG_POS_FIRST + CFG_LEN - 2);
  localparam logic [7:0] CFG_FIRST    = 8'(CFG_POS_FIRST);
  localparam logic [7:0] CFG_LAST     = 8'(CFG_POS_FIRST + CFG_LEN - 1);

  ilas_state_t state, state_nxt;
  logic [7:0]  pos, pos_nxt;
  logic [3:0]  mf, mf_nxt;
  logic        done_q, done_nxt;
  logic        cfg_mf;

  assign cfg_mf = (state == RUN) && (mf == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pos    <= '0;
      mf     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      mf     <= mf_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    mf_nxt    = mf;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = RUN;
          pos_nxt   = '0;
          mf_nxt    = '0;
        end
      end
      RUN: begin
        if (pos == POS_LAST) begin
          pos_nxt = '0;
          if (mf == MF_LAST) begin
            state_nxt = IDLE;
            mf_nxt    = '0;
            done_nxt  = 1'b1;
          end else begin
            mf_nxt = mf + 4'd1;
          end
        end else begin
          pos_nxt = pos + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ILAS_CHKSUM_EN
  logic [7:0] chk_acc;

  // Sum covers octets 0..12, which arrive at positions 2..14.
  always_ff @(posedge clk) begin
    if (cfg_mf) begin
      if (pos == CFG_RD_FIRST)
        chk_acc <= '0;
      else if (pos >= CFG_FIRST && pos < CFG_LAST)
        chk_acc <= chk_acc + bus.i_rom_data;
    end
  end
`endif

  // Reads lead the config slots by one cycle to match the ROM's registered output.
  always_comb begin
    bus.o_rom_rd_en = 1'b0;
    bus.o_rom_addr  = '0;
    if (cfg_mf && pos >= CFG_RD_FIRST && pos <= CFG_RD_LAST) begin
      bus.o_rom_rd_en = 1'b1;
      bus.o_rom_addr  = ADDR_WIDTH'(CFG_BASE + int'(pos) - 1);
    end
  end

  always_comb begin
    bus.o_valid = 1'b0;
    bus.o_data  = '0;
    bus.o_is_k  = 1'b0;
    if (state == RUN) begin
      bus.o_valid = 1'b1;
      if (pos == 8'd0) begin
        bus.o_data = K_R;
        bus.o_is_k = 1'b1;
      end else if (pos == POS_LAST) begin
        bus.o_data = K_A;
        bus.o_is_k = 1'b1;
      end else if (cfg_mf && pos == CFG_RD_FIRST) begin
        bus.o_data = K_Q;
        bus.o_is_k = 1'b1;
      end else if (cfg_mf && pos >= CFG_FIRST && pos <= CFG_LAST) begin
`ifdef ILAS_CHKSUM_EN
        bus.o_data = (pos == CFG_LAST) ? chk_acc : bus.i_rom_data;
`else
        bus.o_data = bus.i_rom_data;
`endif
      end else begin
        bus.o_data = pos;
      end
    end
  end

  assign o_busy = (state == RUN);
  assign o_done = done_q;

endmodule
